// File: rtl/exec_stage_md.sv
// rtl/exec_stage_md.sv - execute stage with single-cycle ALU, HI/LO multiply and restoring divide
module exec_stage_md #(
    parameter int XLEN = 32,
    localparam int SHW = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [SHW-1:0]  in_sa,
    input  logic [4:0]      in_dst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_dst,
    output logic [XLEN-1:0] out_pc,
    output logic            out_wen
);
    localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_AND = 5'd2, OP_OR = 5'd3,
                           OP_XOR = 5'd4, OP_NOR = 5'd5, OP_SLT = 5'd6, OP_SLTU = 5'd7,
                           OP_SLL = 5'd8, OP_SRL = 5'd9, OP_SRA = 5'd10, OP_PASSB = 5'd11,
                           OP_PASSA = 5'd12, OP_MULT = 5'd13, OP_MULTU = 5'd14, OP_DIV = 5'd15,
                           OP_DIVU = 5'd16, OP_MFHI = 5'd17, OP_MFLO = 5'd18, OP_MTHI = 5'd19,
                           OP_MTLO = 5'd20;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_t;

    state_t            state_q, state_d;
    logic              out_valid_q, out_valid_d, out_wen_q, out_wen_d;
    logic [XLEN-1:0]   out_result_q, out_result_d, out_pc_q, out_pc_d;
    logic [4:0]        out_dst_q, out_dst_d, pdst_q, pdst_d;
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [XLEN-1:0]   opa_q, opa_d, opb_q, opb_d, rem_q, rem_d, dvd_q, dvd_d, ppc_q, ppc_d;
    logic [SHW-1:0]    cnt_q, cnt_d;
    logic              done_q, done_d, sgn_q, sgn_d, negq_q, negq_d, negr_q, negr_d;
    logic              div0_q, div0_d;

    logic [XLEN-1:0]   alu_res;
    logic              alu_wen;
    logic [2*XLEN-1:0] mul_ea, mul_eb, mul_prod;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_sub, quo_nxt, rem_nxt, quo_raw, rem_raw, div_lo, div_hi;
    logic              slot_free, accept, is_div_op;

    assign slot_free = !out_valid_q || out_ready;
    assign in_ready  = (state_q == ST_IDLE) && slot_free && !flush;
    assign accept    = in_valid && in_ready;
    assign is_div_op = (in_op == OP_DIV) || (in_op == OP_DIVU);

    always_comb begin
        alu_res = '0;
        case (in_op)
            OP_ADD:   alu_res = in_a + in_b;
            OP_SUB:   alu_res = in_a - in_b;
            OP_AND:   alu_res = in_a & in_b;
            OP_OR:    alu_res = in_a | in_b;
            OP_XOR:   alu_res = in_a ^ in_b;
            OP_NOR:   alu_res = ~(in_a | in_b);
            OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(in_a) < $signed(in_b)};
            OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, in_a < in_b};
            OP_SLL:   alu_res = in_b << in_sa;
            OP_SRL:   alu_res = in_b >> in_sa;
            OP_SRA:   alu_res = $unsigned($signed(in_b) >>> in_sa);
            OP_PASSB: alu_res = in_b;
            OP_PASSA: alu_res = in_a;
            OP_MFHI:  alu_res = hi_q;
            OP_MFLO:  alu_res = lo_q;
            default:  alu_res = '0;
        endcase
        alu_wen = (in_op <= OP_PASSA) || (in_op == OP_MFHI) || (in_op == OP_MFLO);
    end

    // Operands are widened with sign or zero so one unsigned multiplier serves both MULT and MULTU.
    always_comb begin
        mul_ea   = {{XLEN{sgn_q & opa_q[XLEN-1]}}, opa_q};
        mul_eb   = {{XLEN{sgn_q & opb_q[XLEN-1]}}, opb_q};
        mul_prod = mul_ea * mul_eb;
    end

    // One restoring step on magnitudes; opa_q shifts out dividend bits and shifts in quotient bits.
    always_comb begin
        div_shift = {rem_q, opa_q[XLEN-1]};
        div_ge    = div_shift >= {1'b0, opb_q};
        div_sub   = div_shift[XLEN-1:0] - opb_q;
        rem_nxt   = div_ge ? div_sub : div_shift[XLEN-1:0];
        quo_nxt   = {opa_q[XLEN-2:0], div_ge};
        quo_raw   = done_q ? opa_q : quo_nxt;
        rem_raw   = done_q ? rem_q : rem_nxt;
        if (div0_q) begin
            div_lo = '1;
            div_hi = dvd_q;
        end else begin
            div_lo = negq_q ? -quo_raw : quo_raw;
            div_hi = negr_q ? -rem_raw : rem_raw;
        end
    end

    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_dst_d    = out_dst_q;
        out_pc_d     = out_pc_q;
        out_wen_d    = out_wen_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        rem_d        = rem_q;
        dvd_d        = dvd_q;
        cnt_d        = cnt_q;
        done_d       = done_q;
        sgn_d        = sgn_q;
        negq_d       = negq_q;
        negr_d       = negr_q;
        div0_d       = div0_q;
        pdst_d       = pdst_q;
        ppc_d        = ppc_q;
        if (flush) begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
            done_d      = 1'b0;
        end else begin
            if (out_valid_q && out_ready) out_valid_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        pdst_d = in_dst;
                        ppc_d  = in_pc;
                        if (in_op == OP_MULT || in_op == OP_MULTU) begin
                            state_d = ST_MUL;
                            opa_d   = in_a;
                            opb_d   = in_b;
                            sgn_d   = (in_op == OP_MULT);
                        end else if (is_div_op) begin
                            state_d = ST_DIV;
                            sgn_d   = (in_op == OP_DIV);
                            opa_d   = (in_op == OP_DIV && in_a[XLEN-1]) ? -in_a : in_a;
                            opb_d   = (in_op == OP_DIV && in_b[XLEN-1]) ? -in_b : in_b;
                            negq_d  = (in_op == OP_DIV) && (in_a[XLEN-1] ^ in_b[XLEN-1]);
                            negr_d  = (in_op == OP_DIV) && in_a[XLEN-1];
                            div0_d  = (in_b == '0);
                            dvd_d   = in_a;
                            rem_d   = '0;
                            cnt_d   = '0;
                            done_d  = 1'b0;
                        end else begin
                            out_valid_d  = 1'b1;
                            out_result_d = alu_res;
                            out_wen_d    = alu_wen;
                            out_dst_d    = in_dst;
                            out_pc_d     = in_pc;
                            if (in_op == OP_MTHI) hi_d = in_a;
                            if (in_op == OP_MTLO) lo_d = in_a;
                        end
                    end
                end
                ST_MUL: begin
                    if (slot_free) begin
                        {hi_d, lo_d} = mul_prod;
                        state_d      = ST_IDLE;
                        out_valid_d  = 1'b1;
                        out_result_d = '0;
                        out_wen_d    = 1'b0;
                        out_dst_d    = pdst_q;
                        out_pc_d     = ppc_q;
                    end
                end
                ST_DIV: begin
                    if (done_q || cnt_q == SHW'(XLEN-1)) begin
                        if (slot_free) begin
                            hi_d         = div_hi;
                            lo_d         = div_lo;
                            done_d       = 1'b0;
                            state_d      = ST_IDLE;
                            out_valid_d  = 1'b1;
                            out_result_d = '0;
                            out_wen_d    = 1'b0;
                            out_dst_d    = pdst_q;
                            out_pc_d     = ppc_q;
                        end else if (!done_q) begin
                            opa_d  = quo_nxt;
                            rem_d  = rem_nxt;
                            done_d = 1'b1;
                        end
                    end else begin
                        opa_d = quo_nxt;
                        rem_d = rem_nxt;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_dst_q    <= '0;
            out_pc_q     <= '0;
            out_wen_q    <= 1'b0;
            hi_q         <= '0;
            lo_q         <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            rem_q        <= '0;
            dvd_q        <= '0;
            cnt_q        <= '0;
            done_q       <= 1'b0;
            sgn_q        <= 1'b0;
            negq_q       <= 1'b0;
            negr_q       <= 1'b0;
            div0_q       <= 1'b0;
            pdst_q       <= '0;
            ppc_q        <= '0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_dst_q    <= out_dst_d;
            out_pc_q     <= out_pc_d;
            out_wen_q    <= out_wen_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            rem_q        <= rem_d;
            dvd_q        <= dvd_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
            sgn_q        <= sgn_d;
            negq_q       <= negq_d;
            negr_q       <= negr_d;
            div0_q       <= div0_d;
            pdst_q       <= pdst_d;
            ppc_q        <= ppc_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_dst    = out_dst_q;
    assign out_pc     = out_pc_q;
    assign out_wen    = out_wen_q;
endmodule

// File: doc/exec_stage_md.md
EXEC_STAGE_MD -- requirements
Module: exec_stage_md

Interface
REQ-001 Parameter XLEN, default 32: datapath width; SHW = clog2(XLEN) is derived and is not a parameter.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-004 flush  in  1  synchronous pipeline kill.
REQ-005 in_valid  in  1  operation offered.
REQ-006 in_ready  out  1  operation accepted when in_valid && in_ready.
REQ-007 in_op  in  5  opcode, encoded as listed in REQ-015.
REQ-008 in_a, in_b  in  XLEN each  operands.
REQ-009 in_sa  in  SHW  shift amount.
REQ-010 in_dst  in  5  destination register.
REQ-011 in_pc  in  XLEN  instruction PC.
REQ-012 out_valid  out  1 / out_ready  in  1  result handshake.
REQ-013 out_result  out  XLEN, out_dst  out  5, out_pc  out  XLEN, out_wen  out  1  register-write enable.

Function
REQ-014 All outputs SHALL be registered; out_* fields SHALL hold stable while out_valid && !out_ready.
REQ-015 Opcodes 0-20 are ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, PASSB, PASSA, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
  - Arithmetic is modulo 2^XLEN.
  - SLT/SLTU produce 1 or 0.
  - Shifts act on in_b by in_sa; SRA is arithmetic.
REQ-016 Opcodes 0-12, MFHI and MFLO SHALL set out_wen=1. MULT..DIVU, MTHI, MTLO and opcodes 21-31 SHALL set out_wen=0. Opcodes 21-31 SHALL give out_result=0.
REQ-017 The FSM SHALL have states IDLE, MUL and DIV.
  - in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
REQ-018 A single-cycle op accepted in cycle N SHALL present out_valid in cycle N+1.
REQ-019 MULT/MULTU accepted in cycle N:
  - SHALL enter MUL for one cycle.
  - In cycle N+2, out_valid=1 (out_wen=0, out_result=0).
  - {HI,LO} SHALL hold the 2*XLEN signed or unsigned product, visible to an MFHI/MFLO accepted from cycle N+2.
REQ-020 DIV/DIVU SHALL use a restoring divider producing 1 quotient bit per cycle, staying XLEN cycles in DIV; out_valid SHALL appear in cycle N+XLEN+1.
REQ-021 Division results SHALL be: LO=quotient, HI=remainder.
  - Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
  - Divisor 0: LO=all ones, HI=dividend.
  - Signed MIN / -1: LO=MIN, HI=0.
REQ-022 If the result slot is still occupied at MUL/DIV completion, the FSM SHALL stay in its state with the result latched until the slot frees; HI/LO SHALL be written exactly once.
REQ-023 MTHI/MTLO SHALL write in_a to HI/LO on acceptance and retire in cycle N+1 with out_wen=0.
REQ-024 flush=1 SHALL:
  - clear out_valid next cycle;
  - abort MUL/DIV to IDLE without writing HI/LO;
  - block acceptance that cycle.
  - flush has priority over all other events.
REQ-025 out_valid && out_ready with no new acceptance SHALL clear out_valid next cycle; simultaneous retire and accept SHALL give back-to-back results.

Reset
REQ-026 On reset assertion, immediately and independent of clk:
  - state=IDLE, out_valid=0, out_result=0, out_dst=0, out_pc=0, out_wen=0, HI=LO=0;
  - in_ready SHALL be 1 one cycle after deassertion.
REQ-027 Reset during DIV SHALL discard the division; no result SHALL retire after deassertion.

Verification (XLEN=32)
REQ-028 ADD a=0xFFFFFFFF, b=1, out_ready=1 -> next cycle out_valid=1, out_result=0, out_wen=1; SRA b=0x80000000 sa=4 -> 0xF8000000.
REQ-029 MULT a=-3, b=5, then MFHI, MFLO -> 0xFFFFFFFF, 0xFFFFFFF1; MULT completion at N+2 with out_wen=0.
REQ-030 DIV a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF, out_valid at N+33; DIVU by 0, a=9 -> LO=0xFFFFFFFF, HI=9.
REQ-031 out_ready held 0 for 5 cycles after SUB 10-3 -> out_result=7 stable throughout, in_ready=0; then out_ready=1 with ORI-type OR pending -> back-to-back retire.
REQ-032 DIV started, flush in cycle N+10 -> out_valid stays 0, HI/LO unchanged, in_ready=1 at N+11; repeat with reset instead -> all outputs 0 immediately.
